cmac_link_monitor: RTL

Qualifies and monitors the CMAC receive link, downstream of the CMAC control block. It consumes the rx_clk-synchronous `sync_rx_aligned` and `reset_rx_datapath` signals. From them it produces:
- a debounced `link_up` level and a change pulse;
- saturating link-loss, glitch and datapath-reset counters;
- a seconds-resolution link uptime counter.

All outputs are rx_clk-synchronous and feed status registers and interrupt logic.

---
 rtl/cmac_link_monitor.sv | 104 ++++++++++
 1 files changed

// File: rtl/cmac_link_monitor.sv
// cmac_link_monitor: debounced CMAC rx link status, loss/glitch/dp-reset stats and uptime.
// Optional glitch counter built only when CMAC_LINK_MON_GLITCH_COUNT_EN is defined.
module cmac_link_monitor #(
   parameter int FREQ_HZ     = 322265625,
   parameter int UP_CYCLES   = 65536,
   parameter int DOWN_CYCLES = 4096
) (
   input  logic        rx_clk,
   input  logic        rx_resetn,
   input  logic        sync_rx_aligned,
   input  logic        reset_rx_datapath,
   input  logic        clear_stats,
   output logic        link_up,
   output logic        link_changed,
   output logic [15:0] link_down_count,
   output logic [15:0] glitch_count,
   output logic [15:0] dp_reset_count,
   output logic [31:0] uptime_sec
);
   localparam int QW = $clog2(UP_CYCLES > DOWN_CYCLES ? UP_CYCLES : DOWN_CYCLES);
   localparam int PW = $clog2(FREQ_HZ);

   typedef enum logic [1:0] {DOWN, QUALIFY, UP, GLITCH} state_t;

   state_t        st, nxt;
   logic [QW-1:0] qual_cnt, qual_nxt;
   logic [PW-1:0] presc;
   logic          up_nxt, loss, enter_up, dp_q, dp_rise, wrap;

   always_ff @(posedge rx_clk or negedge rx_resetn)
      if (!rx_resetn) begin
         st       <= DOWN;
         qual_cnt <= '0;
      end else begin
         st       <= nxt;
         qual_cnt <= qual_nxt;
      end

   // datapath reset outranks alignment in both link-up states
   always_comb begin
      nxt      = st;
      qual_nxt = qual_cnt;
      case (st)
         DOWN:
            if (sync_rx_aligned) begin
               nxt      = QUALIFY;
               qual_nxt = QW'(1);
            end
         QUALIFY:
            if (!sync_rx_aligned) nxt = DOWN;
            else if (qual_cnt == QW'(UP_CYCLES - 1)) nxt = UP;
            else qual_nxt = qual_cnt + QW'(1);
         UP:
            if (reset_rx_datapath) nxt = DOWN;
            else if (!sync_rx_aligned) begin
               nxt      = GLITCH;
               qual_nxt = QW'(1);
            end
         GLITCH:
            if (reset_rx_datapath) nxt = DOWN;
            else if (sync_rx_aligned) nxt = UP;
            else if (qual_cnt == QW'(DOWN_CYCLES - 1)) nxt = DOWN;
            else qual_nxt = qual_cnt + QW'(1);
      endcase
   end

   always_comb begin
      link_up  = (st == UP) || (st == GLITCH);
      up_nxt   = (nxt == UP) || (nxt == GLITCH);
      loss     = link_up && (nxt == DOWN);
      enter_up = (st == QUALIFY) && (nxt == UP);
      dp_rise  = reset_rx_datapath && !dp_q;
      wrap     = presc == PW'(FREQ_HZ - 1);
   end

   always_ff @(posedge rx_clk or negedge rx_resetn)
      if (!rx_resetn) begin
         link_changed    <= 1'b0;
         dp_q            <= 1'b0;
         link_down_count <= '0;
         dp_reset_count  <= '0;
         presc           <= '0;
         uptime_sec      <= '0;
      end else begin
         link_changed    <= up_nxt != link_up;
         dp_q            <= reset_rx_datapath;
         link_down_count <= clear_stats ? '0 : link_down_count + 16'(loss && !(&link_down_count));
         dp_reset_count  <= clear_stats ? '0 : dp_reset_count + 16'(dp_rise && !(&dp_reset_count));
         // prescaler only runs while the link is up; uptime freezes on link loss
         presc           <= (clear_stats || enter_up) ? '0 : !link_up ? presc : wrap ? '0 : presc + PW'(1);
         uptime_sec      <= (clear_stats || enter_up) ? '0 :
                            uptime_sec + 32'(link_up && wrap && !(&uptime_sec));
      end

`ifdef CMAC_LINK_MON_GLITCH_COUNT_EN
   logic recover;
   assign recover = (st == GLITCH) && (nxt == UP);
   always_ff @(posedge rx_clk or negedge rx_resetn)
      if (!rx_resetn) glitch_count <= '0;
      else glitch_count <= clear_stats ? '0 : glitch_count + 16'(recover && !(&glitch_count));
`else
   assign glitch_count = '0;
`endif
endmodule
